// File: rtl/fsk_pkg.sv
// rtl/fsk_pkg.sv - shared FSK framing and tone constants for modulator and demodulator
package fsk_pkg;
    localparam int BIT_CYCLES = 16;
    localparam int WORD_BITS  = 16;
    localparam int MARK_HALF  = 2;
    localparam int SPACE_HALF = 4;
    localparam int LOW_MAX    = 5;
    localparam int HIGH_MIN   = 7;
endpackage

// File: rtl/fsk_bit_slicer.sv
// rtl/fsk_bit_slicer.sv - counts line transitions per bit window and slices each window to one bit
module fsk_bit_slicer #(
    parameter int BIT_CYCLES = fsk_pkg::BIT_CYCLES,
    parameter int LOW_MAX    = fsk_pkg::LOW_MAX,
    parameter int HIGH_MIN   = fsk_pkg::HIGH_MIN
) (
    input  logic clk,
    input  logic rst,
    input  logic data_in,
    input  logic sync,
    output logic slice_bit,
    output logic bit_strobe,
    output logic ambiguous
);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam int EW = $clog2(BIT_CYCLES + 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [EW:0]   LOW_LIM  = (EW + 1)'(LOW_MAX);
    localparam logic [EW:0]   HIGH_LIM = (EW + 1)'(HIGH_MIN);

    logic          prev_in_q, prev_in_d;
    logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [EW-1:0] edge_cnt_q, edge_cnt_d;
    logic          edge_now;
    logic          last_cyc;
    logic [EW:0]   n_edges;

    // Edge detect, window counters and the end-of-window decision (current edge included)
    always_comb begin
        edge_now   = data_in ^ prev_in_q;
        last_cyc   = (cyc_cnt_q == CYC_LAST);
        n_edges    = {1'b0, edge_cnt_q} + (EW + 1)'(edge_now);
        slice_bit  = (n_edges > LOW_LIM);
        bit_strobe = last_cyc && !sync;
        ambiguous  = bit_strobe && slice_bit && (n_edges < HIGH_LIM);
        prev_in_d  = data_in;
        cyc_cnt_d  = cyc_cnt_q + CW'(1);
        edge_cnt_d = edge_cnt_q + EW'(edge_now);
        if (sync) begin
            // The sync cycle itself is window cycle 0, so the next cycle is cycle 1
            cyc_cnt_d  = CW'(1);
            edge_cnt_d = '0;
        end else if (last_cyc) begin
            cyc_cnt_d  = '0;
            edge_cnt_d = '0;
        end
    end

    // Window state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_in_q  <= 1'b0;
            cyc_cnt_q  <= '0;
            edge_cnt_q <= '0;
        end else begin
            prev_in_q  <= prev_in_d;
            cyc_cnt_q  <= cyc_cnt_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    // Overlapping thresholds would make the 0/1/ambiguous split meaningless
    always_ff @(posedge clk) begin
        assert (LOW_MAX < HIGH_MIN) else $error("fsk_bit_slicer: LOW_MAX must be below HIGH_MIN");
    end
endmodule

// File: rtl/fsk_demod.sv
// rtl/fsk_demod.sv - FSK receive stage assembling sliced bits MSB first into words
module fsk_demod #(
    parameter int BIT_CYCLES = fsk_pkg::BIT_CYCLES,
    parameter int WORD_BITS  = fsk_pkg::WORD_BITS,
    parameter int LOW_MAX    = fsk_pkg::LOW_MAX,
    parameter int HIGH_MIN   = fsk_pkg::HIGH_MIN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_in,
    input  logic                 sync,
    output logic [WORD_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 err
);
    localparam int IW = $clog2(WORD_BITS);
    localparam logic [IW-1:0] IDX_LAST = IW'(WORD_BITS - 1);

    logic                 slice_bit;
    logic                 bit_strobe;
    logic                 ambiguous;
    logic [WORD_BITS-2:0] shreg_q, shreg_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic                 err_acc_q, err_acc_d;
    logic [WORD_BITS-1:0] data_out_q, data_out_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;

    fsk_bit_slicer #(
        .BIT_CYCLES (BIT_CYCLES),
        .LOW_MAX    (LOW_MAX),
        .HIGH_MIN   (HIGH_MIN)
    ) u_slicer (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .sync       (sync),
        .slice_bit  (slice_bit),
        .bit_strobe (bit_strobe),
        .ambiguous  (ambiguous)
    );

    // Shift sliced bits in, publish the word and its error flag on the last bit
    always_comb begin
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        err_acc_d  = err_acc_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        err_d      = err_q;
        if (sync) begin
            // Realign framing; the last good word stays visible
            shreg_d   = '0;
            bit_idx_d = '0;
            err_acc_d = 1'b0;
            err_d     = 1'b0;
        end else if (bit_strobe) begin
            shreg_d   = {shreg_q[WORD_BITS-3:0], slice_bit};
            err_acc_d = err_acc_q | ambiguous;
            if (bit_idx_q == IDX_LAST) begin
                data_out_d = {shreg_q, slice_bit};
                err_d      = err_acc_q | ambiguous;
                valid_d    = 1'b1;
                err_acc_d  = 1'b0;
                bit_idx_d  = '0;
            end else begin
                bit_idx_d = bit_idx_q + IW'(1);
            end
        end
    end

    // Word assembly and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            err_acc_q  <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            err_acc_q  <= err_acc_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;
    assign err      = err_q;
endmodule

// File: tb/tb_fsk_demod.sv
// tb/tb_fsk_demod.sv - directed self-checking bench for fsk_demod
module tb_fsk_demod;
    logic        clk;
    logic        rst;
    logic        data_in;
    logic        sync;
    logic [15:0] data_out;
    logic        valid;
    logic        err;

    int          vectors;
    int          miscompares;
    logic        line;
    logic [15:0] exp_data;
    logic        exp_err;

    fsk_demod dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .sync     (sync),
        .data_out (data_out),
        .valid    (valid),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic din, input logic sy);
        data_in = din;
        sync    = sy;
        @(posedge clk);
        #1;
    endtask

    // Outputs that must hold on any cycle without a strobe
    task automatic chk_idle_cycle(input string tag);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
        chk({tag, "_data"}, {16'd0, data_out}, {16'd0, exp_data});
        chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    // One word from a model modulator: mark toggles every MARK_HALF cycles, space every SPACE_HALF.
    // amb_pos selects a window driven with exactly 6 transitions instead; idle leaves the line flat.
    task automatic send_word(input string tag, input logic [15:0] w, input int amb_pos,
                             input bit idle, input bit sync_first,
                             input logic [15:0] exp_w, input logic exp_e);
        for (int i = 15; i >= 0; i--) begin
            for (int c = 0; c < 16; c++) begin
                bit tog;
                bit sy;
                if (idle)
                    tog = 1'b0;
                else if (i == amb_pos)
                    tog = (c < 12) && (c % 2 == 0);
                else
                    tog = (c % (w[i] ? fsk_pkg::MARK_HALF : fsk_pkg::SPACE_HALF)) == 0;
                if (tog) line = ~line;
                sy = sync_first && (i == 15) && (c == 0);
                step(line, sy);
                if (sy) exp_err = 1'b0;
                if (i == 0 && c == 15) begin
                    exp_data = exp_w;
                    exp_err  = exp_e;
                    chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
                    chk({tag, "_data"}, {16'd0, data_out}, {16'd0, exp_w});
                    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_e});
                end else begin
                    chk_idle_cycle(tag);
                end
            end
        end
    endtask

    // Clean mark tone for a number of cycles without completing a word
    task automatic send_partial(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            if (k % 2 == 0) line = ~line;
            step(line, 1'b0);
            chk_idle_cycle(tag);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        data_in     = 1'b0;
        sync        = 1'b0;
        line        = 1'b0;
        exp_data    = 16'h0000;
        exp_err     = 1'b0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", {16'd0, data_out}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;

        // Idle line decodes as all zeros, strobe after 256 cycles
        send_word("idle", 16'h0000, -1, 1'b1, 1'b0, 16'h0000, 1'b0);
        // Back-to-back modulated words
        send_word("ffff", 16'hFFFF, -1, 1'b0, 1'b0, 16'hFFFF, 1'b0);
        send_word("zero", 16'h0000, -1, 1'b0, 1'b0, 16'h0000, 1'b0);
        // MSB-first ordering
        send_word("a5c3", 16'hA5C3, -1, 1'b0, 1'b0, 16'hA5C3, 1'b0);
        // Bit 8 window ambiguous: decodes as 1 and flags err; next clean word clears it
        send_word("amb", 16'h1234, 8, 1'b0, 1'b0, 16'h1334, 1'b1);
        send_word("clean", 16'h8001, -1, 1'b0, 1'b0, 16'h8001, 1'b0);
        // Sync 100 cycles into a word, restarted modulator sends 0x0F0F
        send_partial("presync", 100);
        send_word("sync", 16'h0F0F, -1, 1'b0, 1'b1, 16'h0F0F, 1'b0);
        // Reset 130 cycles into a word, framing restarts from release
        send_partial("prerst", 130);
        rst  = 1'b1;
        line = 1'b0;
        step(line, 1'b0);
        rst = 1'b0;
        exp_data = 16'h0000;
        exp_err  = 1'b0;
        chk("midrst_data", {16'd0, data_out}, 32'd0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        send_word("postrst", 16'h5A5A, -1, 1'b0, 1'b0, 16'h5A5A, 1'b0);
        // Strobe lasts exactly one cycle
        step(line, 1'b0);
        chk_idle_cycle("tail");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fsk_demod.md
Name: fsk_demod

Overview:
- Downstream receive stage for the FSK modulator; consumes its 1-bit line output.
- Per bit window, counts line transitions and slices each window to one bit.
- Assembles WORD_BITS bits, MSB first, into a parallel word with a one-cycle valid strobe.
- Both ends share rst, so bit and word windows are aligned from reset; `sync` gives explicit re-alignment.

Parameters:
- BIT_CYCLES, 16: clock cycles per bit window.
- WORD_BITS, 16: bits per assembled word.
- LOW_MAX, 5: transition count at or below which the window decodes as 0 (space, half-period 4 → 4 transitions).
- HIGH_MIN, 7: transition count at or above which the window decodes as 1 (mark, half-period 2 → 8 transitions).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- data_in  in  1  FSK line from the modulator.
- sync  in  1  synchronous realign strobe; restarts bit and word framing.
- data_out  out  WORD_BITS  last fully received word.
- valid  out  1  one-cycle strobe; data_out and err updated.
- err  out  1  at least one ambiguous window in the last word.

Behaviour:
- One clock; reset is synchronous and active-high. Reset values: data_out=0, valid=0, err=0. Internal: prev_in=0, cyc_cnt=0, edge_cnt=0, bit_idx=0, shreg=0, err_acc=0.
- Priority per cycle: rst > sync > normal operation. sync performs the same clears as rst except data_out, which holds its value. valid=0 in a sync cycle. The sync cycle counts as cycle 0 of a new window; data_in is sampled into prev_in.
- Edge detect: edge = data_in ^ prev_in. prev_in <= data_in every cycle.
- Window: cyc_cnt runs 0..BIT_CYCLES-1 and wraps. edge_cnt accumulates edges. Width is $clog2(BIT_CYCLES+1), so it saturates naturally and never wraps.
- Decision at cyc_cnt==BIT_CYCLES-1: n = edge_cnt + edge (the current cycle is included).
  - n ≤ LOW_MAX → bit 0.
  - n ≥ HIGH_MIN → bit 1.
  - Otherwise → bit 1 and err_acc <= 1.
  - edge_cnt is cleared for the next window.
- Shift: shreg <= {shreg[WORD_BITS-2:0], bit}. bit_idx increments and wraps at WORD_BITS-1.
- Word completion at the decision with bit_idx==WORD_BITS-1:
  - data_out <= {shreg[WORD_BITS-2:0], bit}.
  - err <= err_acc | ambiguous_now.
  - valid <= 1 for exactly one cycle.
  - err_acc cleared.
- Latency: valid rises on the clock edge after the last sample of the word. That is cycle WORD_BITS*BIT_CYCLES (256 by default), counting the first post-reset cycle as 0.
- valid is otherwise 0. data_out and err hold between strobes.
- Stuck line (0 transitions) → bit 0, no err.
- Illegal parameters (LOW_MAX ≥ HIGH_MIN) are not supported; add an assertion in simulation.
- FSM: single running state. It is implicit in the counters, not a named state register; sync/rst are the only entry points.

Decomposition:
- Package fsk_pkg: BIT_CYCLES, WORD_BITS, MARK_HALF=2, SPACE_HALF=4, LOW_MAX, HIGH_MIN. Shared with the modulator so both ends agree.
- Sub-module fsk_bit_slicer: edge detect, cycle counter, edge counter, decision. Outputs bit, bit_strobe, ambiguous.
- fsk_demod top: shift register, bit_idx, word/err/valid output.

Test Plan:
1. Reset held 3 cycles, then released with line idle 0 → data_out=0x0000, valid=0, err=0 throughout the first 255 cycles; at cycle 256, valid=1, data_out=0x0000, err=0.
2. Modulator-generated 0xFFFF then 0x0000, back-to-back, aligned from reset → valid at cycles 256 and 512 with 0xFFFF then 0x0000, err=0, valid high exactly 1 cycle each.
3. Word 0xA5C3 from the modulator → data_out=0xA5C3. Checks MSB-first ordering.
4. One window driven with exactly 6 transitions, all other bits as 0x1234 → data_out has that bit = 1, err=1 on that strobe. The next clean word gives err=0.
5. Assert sync at cycle 100 mid-word, then a modulator restarted at that cycle sends 0x0F0F → valid at cycle 100+256 with 0x0F0F. The old data_out holds until then.
6. Assert rst mid-word at cycle 130 after a prior valid word → data_out=0 and valid=0 next cycle, and framing restarts from the release point.
